// File: rtl/button_event_fifo.sv
// Timestamped button-event FIFO feeding a PIO port; software pops on POP_I rising edges.
// Build option: define EVTQ_DROP_OLDEST_EN to keep the newest events on overflow (default keeps oldest).
module button_event_fifo #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 2
) (
  input  logic          CLK_I,
  input  logic          RST_N_I,
  input  logic          EVT_I,
  input  logic [DW-1:0] TSTAMP_I,
  input  logic          POP_I,
  input  logic          CLR_I,
  output logic [DW-1:0] DATA_O,
  output logic [AW:0]   COUNT_O,
  output logic          EMPTY_O,
  output logic          OVF_O
);

  localparam int unsigned DEPTH    = 1 << AW;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          pop_dly_q, pop_dly_d;

  logic pop_req;
  logic pop_ok;
  logic full;
  logic empty;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == FULL_CNT);
  assign pop_req = POP_I & ~pop_dly_q;
  assign pop_ok  = pop_req & ~empty;

  always_comb begin
    mem_d     = mem_q;
    wp_d      = wp_q;
    rp_d      = rp_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    pop_dly_d = POP_I;

    if (CLR_I) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (EVT_I && pop_ok) begin
      // A pop frees a slot on the same edge, so a push into a full queue is not an overflow.
      mem_d[wp_q] = TSTAMP_I;
      wp_d        = wp_q + AW'(1);
      rp_d        = rp_q + AW'(1);
    end else if (EVT_I && !full) begin
      mem_d[wp_q] = TSTAMP_I;
      wp_d        = wp_q + AW'(1);
      cnt_d       = cnt_q + (AW+1)'(1);
    end else if (EVT_I) begin
      ovf_d = 1'b1;
`ifdef EVTQ_DROP_OLDEST_EN
      // Full: wp == rp, so the oldest slot is overwritten and both pointers step.
      mem_d[wp_q] = TSTAMP_I;
      wp_d        = wp_q + AW'(1);
      rp_d        = rp_q + AW'(1);
`else
      mem_d = mem_q;
`endif
    end else if (pop_ok) begin
      rp_d  = rp_q + AW'(1);
      cnt_d = cnt_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge CLK_I or negedge RST_N_I) begin
    if (!RST_N_I) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wp_q      <= '0;
      rp_q      <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      pop_dly_q <= 1'b1;
    end else begin
      mem_q     <= mem_d;
      wp_q      <= wp_d;
      rp_q      <= rp_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      pop_dly_q <= pop_dly_d;
    end
  end

  assign DATA_O  = empty ? '0 : mem_q[rp_q];
  assign COUNT_O = cnt_q;
  assign EMPTY_O = empty;
  assign OVF_O   = ovf_q;

endmodule

// File: tb/tb_button_event_fifo.sv
// Self-checking bench for button_event_fifo against a queue-based reference model.
module tb_button_event_fifo;

  localparam int DW = 8;
  localparam int AW = 2;
  localparam int DEPTH = 4;

  logic          CLK_I = 1'b0;
  logic          RST_N_I;
  logic          EVT_I;
  logic [DW-1:0] TSTAMP_I;
  logic          POP_I;
  logic          CLR_I;
  logic [DW-1:0] DATA_O;
  logic [AW:0]   COUNT_O;
  logic          EMPTY_O;
  logic          OVF_O;

  int total = 0;
  int bad   = 0;

  byte unsigned mq[$];
  bit           m_ovf;
  bit           m_prev;

  button_event_fifo #(.DW(DW), .AW(AW)) dut (
    .CLK_I(CLK_I), .RST_N_I(RST_N_I), .EVT_I(EVT_I), .TSTAMP_I(TSTAMP_I),
    .POP_I(POP_I), .CLR_I(CLR_I), .DATA_O(DATA_O), .COUNT_O(COUNT_O),
    .EMPTY_O(EMPTY_O), .OVF_O(OVF_O)
  );

  always #5 CLK_I = ~CLK_I;

  function automatic logic [14:0] m_exp();
    logic [7:0] d;
    d = (mq.size() != 0) ? mq[0] : 8'h00;
    return {d, 3'(mq.size()), mq.size() == 0, m_ovf};
  endfunction

  task automatic m_reset();
    mq.delete();
    m_ovf  = 1'b0;
    m_prev = 1'b1;
  endtask

  task automatic m_update(input bit evt, input byte unsigned ts, input bit pop, input bit clr);
    bit preq, dopop;
    preq   = pop && !m_prev;
    m_prev = pop;
    if (clr) begin
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      dopop = preq && mq.size() > 0;
      if (evt && dopop) begin
        void'(mq.pop_front());
        mq.push_back(ts);
      end else if (evt && mq.size() < DEPTH) begin
        mq.push_back(ts);
      end else if (evt) begin
        m_ovf = 1'b1;
`ifdef EVTQ_DROP_OLDEST_EN
        void'(mq.pop_front());
        mq.push_back(ts);
`endif
      end else if (dopop) begin
        void'(mq.pop_front());
      end
    end
  endtask

  task automatic step(input bit evt, input byte unsigned ts, input bit pop, input bit clr);
    EVT_I = evt; TSTAMP_I = ts; POP_I = pop; CLR_I = clr;
    @(posedge CLK_I);
    m_update(evt, ts, pop, clr);
    @(negedge CLK_I);
  endtask

  task automatic test_reset();
    RST_N_I = 1'b0; EVT_I = 1'b0; TSTAMP_I = '0; POP_I = 1'b1; CLR_I = 1'b0;
    m_reset();
    repeat (3) @(negedge CLK_I);
    total++;
    if ({DATA_O, COUNT_O, EMPTY_O, OVF_O} !== {8'h00, 3'd0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL reset_state got=%h exp=%h", {DATA_O, COUNT_O, EMPTY_O, OVF_O}, {8'h00, 3'd0, 1'b1, 1'b0});
    end
    RST_N_I = 1'b1;
    repeat (3) step(0, 0, 1, 0);
    total++;
    if ({COUNT_O, EMPTY_O} !== {3'd0, 1'b1}) begin
      bad++;
      $display("FAIL reset_idle got=%h exp=%h", {COUNT_O, EMPTY_O}, {3'd0, 1'b1});
    end
    step(1, 8'hC4, 1, 0);
    step(0, 0, 1, 0);
    total++;
    if ({DATA_O, COUNT_O} !== {8'hC4, 3'd1}) begin
      bad++;
      $display("FAIL reset_pop_held got=%h exp=%h", {DATA_O, COUNT_O}, {8'hC4, 3'd1});
    end
    step(0, 0, 0, 1);
  endtask

  task automatic test_single();
    step(1, 8'h3A, 0, 0);
    total++;
    if ({DATA_O, COUNT_O, EMPTY_O} !== {8'h3A, 3'd1, 1'b0}) begin
      bad++;
      $display("FAIL single_push got=%h exp=%h", {DATA_O, COUNT_O, EMPTY_O}, {8'h3A, 3'd1, 1'b0});
    end
    step(0, 0, 1, 0);
    total++;
    if ({DATA_O, COUNT_O, EMPTY_O} !== {8'h00, 3'd0, 1'b1}) begin
      bad++;
      $display("FAIL single_pop got=%h exp=%h", {DATA_O, COUNT_O, EMPTY_O}, {8'h00, 3'd0, 1'b1});
    end
    step(1, 8'h55, 1, 0);
    repeat (9) step(0, 0, 1, 0);
    total++;
    if ({DATA_O, COUNT_O} !== {8'h55, 3'd1}) begin
      bad++;
      $display("FAIL single_hold got=%h exp=%h", {DATA_O, COUNT_O}, {8'h55, 3'd1});
    end
    step(0, 0, 0, 1);
  endtask

  task automatic test_ordering();
    for (int i = 1; i <= 4; i++) step(1, 8'(i), 0, 0);
    total++;
    if (COUNT_O !== 3'd4) begin
      bad++;
      $display("FAIL order_count got=%0d exp=4", COUNT_O);
    end
    for (int i = 1; i <= 4; i++) begin
      total++;
      if (DATA_O !== 8'(i)) begin
        bad++;
        $display("FAIL order_head%0d got=%h exp=%h", i, DATA_O, 8'(i));
      end
      step(0, 0, 1, 0);
      step(0, 0, 0, 0);
    end
    total++;
    if ({DATA_O, EMPTY_O, OVF_O} !== {8'h00, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL order_end got=%h exp=%h", {DATA_O, EMPTY_O, OVF_O}, {8'h00, 1'b1, 1'b0});
    end
  endtask

  task automatic test_overflow();
    byte unsigned exp_seq[4];
`ifdef EVTQ_DROP_OLDEST_EN
    exp_seq = '{8'd2, 8'd3, 8'd4, 8'd5};
`else
    exp_seq = '{8'd1, 8'd2, 8'd3, 8'd4};
`endif
    for (int i = 1; i <= 5; i++) step(1, 8'(i), 0, 0);
    total++;
    if ({COUNT_O, OVF_O} !== {3'd4, 1'b1}) begin
      bad++;
      $display("FAIL ovf_flag got=%h exp=%h", {COUNT_O, OVF_O}, {3'd4, 1'b1});
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (DATA_O !== exp_seq[i]) begin
        bad++;
        $display("FAIL ovf_drain%0d got=%h exp=%h", i, DATA_O, exp_seq[i]);
      end
      step(0, 0, 1, 0);
      step(0, 0, 0, 0);
    end
    total++;
    if ({COUNT_O, OVF_O} !== {3'd0, 1'b1}) begin
      bad++;
      $display("FAIL ovf_sticky got=%h exp=%h", {COUNT_O, OVF_O}, {3'd0, 1'b1});
    end
    step(0, 0, 0, 1);
  endtask

  task automatic test_simultaneous();
    byte unsigned exp_seq[4];
    exp_seq = '{8'd2, 8'd3, 8'd4, 8'd9};
    for (int i = 1; i <= 4; i++) step(1, 8'(i), 0, 0);
    step(1, 8'd9, 1, 0);
    total++;
    if ({COUNT_O, OVF_O} !== {3'd4, 1'b0}) begin
      bad++;
      $display("FAIL simul_full got=%h exp=%h", {COUNT_O, OVF_O}, {3'd4, 1'b0});
    end
    step(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (DATA_O !== exp_seq[i]) begin
        bad++;
        $display("FAIL simul_drain%0d got=%h exp=%h", i, DATA_O, exp_seq[i]);
      end
      step(0, 0, 1, 0);
      step(0, 0, 0, 0);
    end
    step(1, 8'h77, 1, 0);
    total++;
    if ({DATA_O, COUNT_O} !== {8'h77, 3'd1}) begin
      bad++;
      $display("FAIL simul_empty got=%h exp=%h", {DATA_O, COUNT_O}, {8'h77, 3'd1});
    end
    step(0, 0, 0, 1);
  endtask

  task automatic test_flush();
    for (int i = 1; i <= 5; i++) step(1, 8'(i), 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    total++;
    if ({COUNT_O, OVF_O} !== {3'd3, 1'b1}) begin
      bad++;
      $display("FAIL flush_pre got=%h exp=%h", {COUNT_O, OVF_O}, {3'd3, 1'b1});
    end
    step(1, 8'hEE, 0, 1);
    step(0, 0, 0, 0);
    total++;
    if ({DATA_O, COUNT_O, EMPTY_O, OVF_O} !== {8'h00, 3'd0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL flush_post got=%h exp=%h", {DATA_O, COUNT_O, EMPTY_O, OVF_O}, {8'h00, 3'd0, 1'b1, 1'b0});
    end
  endtask

  task automatic test_async_reset();
    step(1, 8'h11, 0, 0);
    step(1, 8'h22, 0, 0);
    #2 RST_N_I = 1'b0;
    m_reset();
    #1;
    total++;
    if ({DATA_O, COUNT_O, EMPTY_O, OVF_O} !== {8'h00, 3'd0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL async_reset got=%h exp=%h", {DATA_O, COUNT_O, EMPTY_O, OVF_O}, {8'h00, 3'd0, 1'b1, 1'b0});
    end
    POP_I = 1'b0;
    @(negedge CLK_I);
    RST_N_I = 1'b1;
  endtask

  task automatic test_random();
    bit pop;
    pop = 1'b0;
    for (int n = 0; n < 600; n++) begin
      pop = ($urandom_range(0, 2) == 0) ? ~pop : pop;
      step($urandom_range(0, 9) < 4, 8'($urandom), pop, $urandom_range(0, 49) == 0);
      total++;
      if ({DATA_O, COUNT_O, EMPTY_O, OVF_O} !== m_exp()) begin
        bad++;
        $display("FAIL random_cyc%0d got=%h exp=%h", n, {DATA_O, COUNT_O, EMPTY_O, OVF_O}, m_exp());
      end
    end
  endtask

  initial begin
    @(negedge CLK_I);
    test_reset();
    test_single();
    test_ordering();
    test_overflow();
    test_simultaneous();
    test_flush();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
